// File: rtl/exu_wb_arb_pkg.sv
// Shared types for the execution-unit writeback arbiter: request struct,
// source priority encoding and the requester filter.
package exu_wb_arb_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // Listed in descending priority; NONE marks an idle cycle.
  typedef enum logic [2:0] {
    WB_SRC_ALU  = 3'd0,
    WB_SRC_FIFO = 3'd1,
    WB_SRC_MUL  = 3'd2,
    WB_SRC_LSU  = 3'd3,
    WB_SRC_DIV  = 3'd4,
    WB_SRC_NONE = 3'd7
  } wb_src_e;

  // Writes to x0 are architecturally discarded, so they never compete.
  function automatic logic is_req(input wb_req_t r);
    return r.valid && (r.rd_addr != 5'd0);
  endfunction

endpackage

// File: rtl/dff_rst.sv
// Generic register with asynchronous active-low reset to a parameterised value.
module dff_rst #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Plain storage element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/exu_wb_arb_wb_fifo.sv
// Circular-buffer FIFO holding multiplier results that lost writeback
// arbitration. A push while full is accepted only if a pop frees a slot.
module wb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 37,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Payload storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: fixed priority ALU > FIFO head > MUL > LSU > DIV onto one
// registered register-file write port, with multiplier overflow buffering.
module exu_wb_arb
  import exu_wb_arb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STALL_THRESH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] alu_wb_data,
  input  logic [4:0]      alu_wb_rd_addr,
  input  logic            alu_wb_rd_wr_en,
  input  logic [XLEN-1:0] mul_wb_data,
  input  logic [4:0]      mul_wb_rd_addr,
  input  logic            mul_wb_valid,
  input  logic [XLEN-1:0] lsu_wb_data,
  input  logic [4:0]      lsu_wb_rd_addr,
  input  logic            lsu_wb_valid,
  output logic            lsu_wb_ready,
  input  logic [XLEN-1:0] div_wb_data,
  input  logic [4:0]      div_wb_rd_addr,
  input  logic            div_wb_valid,
  output logic            div_wb_ready,
  output logic            rf_wr_en,
  output logic [4:0]      rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  output logic            mul_stall,
  output logic            wb_ovf
);

  localparam int FW = 5 + XLEN;
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t       alu_s, mul_s, lsu_s, div_s, head_s;
  logic          alu_req_s, fifo_req_s, mul_req_s, lsu_req_s, div_req_s;
  wb_src_e       grant_s;
  logic [4:0]    sel_addr_s;
  logic [XLEN-1:0] sel_data_s;
  logic          push_s, pop_s;
  logic [FW-1:0] head_raw_s;
  logic [CW-1:0] count_s, next_count_s;
  logic          full_s, empty_s;
  logic          ovf_now_s, stall_next_s, ovf_next_s;

  assign alu_s  = '{valid: alu_wb_rd_wr_en, rd_addr: alu_wb_rd_addr, data: alu_wb_data};
  assign mul_s  = '{valid: mul_wb_valid, rd_addr: mul_wb_rd_addr, data: mul_wb_data};
  assign lsu_s  = '{valid: lsu_wb_valid, rd_addr: lsu_wb_rd_addr, data: lsu_wb_data};
  assign div_s  = '{valid: div_wb_valid, rd_addr: div_wb_rd_addr, data: div_wb_data};
  assign head_s = '{valid: !empty_s, rd_addr: head_raw_s[FW-1:XLEN], data: head_raw_s[XLEN-1:0]};

  assign alu_req_s  = is_req(alu_s);
  assign fifo_req_s = is_req(head_s);
  assign mul_req_s  = is_req(mul_s);
  assign lsu_req_s  = is_req(lsu_s);
  assign div_req_s  = is_req(div_s);

  // x0 results are acknowledged immediately so the producer never stalls on them.
  assign lsu_wb_ready = lsu_s.valid &&
                        ((lsu_s.rd_addr == 5'd0) || !(alu_req_s || fifo_req_s || mul_req_s));
  assign div_wb_ready = div_s.valid &&
                        ((div_s.rd_addr == 5'd0) ||
                         !(alu_req_s || fifo_req_s || mul_req_s || lsu_req_s));

  // Priority select; MUL goes direct only when it cannot overtake buffered entries.
  always_comb begin
    grant_s    = WB_SRC_NONE;
    sel_addr_s = 5'd0;
    sel_data_s = {XLEN{1'b0}};
    if (alu_req_s) begin
      grant_s    = WB_SRC_ALU;
      sel_addr_s = alu_s.rd_addr;
      sel_data_s = alu_s.data;
    end else if (fifo_req_s) begin
      grant_s    = WB_SRC_FIFO;
      sel_addr_s = head_s.rd_addr;
      sel_data_s = head_s.data;
    end else if (mul_req_s && empty_s) begin
      grant_s    = WB_SRC_MUL;
      sel_addr_s = mul_s.rd_addr;
      sel_data_s = mul_s.data;
    end else if (lsu_req_s) begin
      grant_s    = WB_SRC_LSU;
      sel_addr_s = lsu_s.rd_addr;
      sel_data_s = lsu_s.data;
    end else if (div_req_s) begin
      grant_s    = WB_SRC_DIV;
      sel_addr_s = div_s.rd_addr;
      sel_data_s = div_s.data;
    end else begin
      grant_s    = WB_SRC_NONE;
    end
  end

  assign pop_s  = (grant_s == WB_SRC_FIFO);
  assign push_s = mul_req_s && (grant_s != WB_SRC_MUL);

  wb_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({mul_s.rd_addr, mul_s.data}),
    .rdata (head_raw_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Occupancy after this cycle's push/pop, mirroring the FIFO's acceptance rule.
  always_comb begin
    next_count_s = count_s;
    case ({push_s && (!full_s || pop_s), pop_s})
      2'b10:   next_count_s = count_s + CW'(1);
      2'b01:   next_count_s = count_s - CW'(1);
      default: next_count_s = count_s;
    endcase
  end

  assign ovf_now_s    = push_s && full_s && !pop_s;
  assign ovf_next_s   = wb_ovf || ovf_now_s;
  assign stall_next_s = ((CW + 1)'(DEPTH) - {1'b0, next_count_s}) <= (CW + 1)'(STALL_THRESH);

  dff_rst #(.W(1))    u_en_q    (.clk(clk), .rst_n(rst_n), .d(grant_s != WB_SRC_NONE), .q(rf_wr_en));
  dff_rst #(.W(5))    u_addr_q  (.clk(clk), .rst_n(rst_n), .d(sel_addr_s),   .q(rf_wr_addr));
  dff_rst #(.W(XLEN)) u_data_q  (.clk(clk), .rst_n(rst_n), .d(sel_data_s),   .q(rf_wr_data));
  dff_rst #(.W(1))    u_stall_q (.clk(clk), .rst_n(rst_n), .d(stall_next_s), .q(mul_stall));
  dff_rst #(.W(1))    u_ovf_q   (.clk(clk), .rst_n(rst_n), .d(ovf_next_s),   .q(wb_ovf));

endmodule
